// File: rtl/iterative_alu_pkg.sv
// Shared types for the iterative execute-stage ALU.
// Op encodings, FSM states and counter sizing helper.
package iterative_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_SLT    = 3'b010,
    OP_SLTU   = 3'b011,
    OP_CLMUL  = 3'b100,
    OP_CLMULH = 3'b101,
    OP_CLMULR = 3'b110,
    OP_XOR    = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } ialu_state_t;

  // Width of the CALC iteration counter.
  function automatic int cnt_w(input int width, input int bpc);
    int k;
    k = width / bpc;
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Carry-less multiplies take the iterative path.
  function automatic logic is_clmul(input alu_op_t op);
    return (op == OP_CLMUL) || (op == OP_CLMULH) || (op == OP_CLMULR);
  endfunction

endpackage

// File: rtl/iterative_alu_clmul_step.sv
// One carry-less multiply step: XOR of A shifted by
// each set bit of a BPC-bit multiplier slice.
module clmul_step
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [BPC-1:0]     b,
  output logic [2*WIDTH-1:0] pp
);

  // Partial product for this slice, unshifted by slice position.
  always_comb begin
    pp = '0;
    for (int j = 0; j < BPC; j++) begin
      if (b[j]) begin
        pp = pp ^ ({{WIDTH{1'b0}}, a} << j);
      end
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle execute ALU: 1-cycle add/sub/slt/sltu/xor,
// BPC-bits-per-cycle clmul*. Option: ITERATIVE_ALU_EARLYOUT_EN.
`ifndef XLEN
`define XLEN 64
`endif

module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int WIDTH = `XLEN,
  parameter int BPC   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             W64,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);

  localparam int K  = WIDTH / BPC;
  localparam int CW = cnt_w(WIDTH, BPC);

  ialu_state_t        state;
  ialu_state_t        state_n;
  alu_op_t            op_in;
  alu_op_t            op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   bsh;
  logic [WIDTH-1:0]   bsh_n;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH-1:0]   simple_res;
  logic [WIDTH-1:0]   clmul_res;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   sum;
  logic               accept;
  logic               last;
  logic               ovf;
  logic               lt;

  assign op_in    = alu_op_t'(Op);
  assign InReady  = (state == IDLE);
  assign Busy     = (state != IDLE);
  assign OutValid = (state == DONE);

  // A flush in the same cycle drops the request.
  assign accept = InValid & InReady & ~Flush;

  clmul_step #(
    .WIDTH(WIDTH),
    .BPC  (BPC)
  ) u_step (
    .a (a_q),
    .b (bsh[BPC-1:0]),
    .pp(pp)
  );

  assign bsh_n = bsh >> BPC;
  assign acc_n = acc ^ (pp << (int'(cnt) * BPC));

`ifdef ITERATIVE_ALU_EARLYOUT_EN
  assign last = (cnt == CW'(K - 1)) | (bsh_n == '0);
`else
  assign last = (cnt == CW'(K - 1));
`endif

  // Single-cycle ops straight from the request operands.
  always_comb begin
    sum  = A + B;
    diff = {1'b0, A} + {1'b0, ~B} + (WIDTH + 1)'(1);
    ovf  = (A[WIDTH-1] ^ B[WIDTH-1]) &
           (diff[WIDTH-1] ^ A[WIDTH-1]);
    lt   = diff[WIDTH-1] ^ ovf;
    simple_res = '0;
    unique case (op_in)
      OP_ADD:  simple_res = sum;
      OP_SUB:  simple_res = diff[WIDTH-1:0];
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, lt};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
      OP_XOR:  simple_res = A ^ B;
      default: simple_res = '0;
    endcase
    if ((WIDTH == 64) && W64 &&
        ((op_in == OP_ADD) || (op_in == OP_SUB))) begin
      for (int i = 32; i < WIDTH; i++) begin
        simple_res[i] = simple_res[31];
      end
    end
  end

  // Final clmul* selection from the last accumulator value.
  always_comb begin
    clmul_res = '0;
    unique case (op_q)
      OP_CLMULH: clmul_res = acc_n[2*WIDTH-1:WIDTH];
      OP_CLMULR: clmul_res = acc_n[2*WIDTH-2:WIDTH-1];
      default:   clmul_res = acc_n[WIDTH-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = is_clmul(op_in) ? CALC : DONE;
        end
      end
      CALC: begin
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (Flush) begin
      state_n = IDLE;
    end
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      bsh    <= '0;
      cnt    <= '0;
      acc    <= '0;
      Result <= '0;
    end else if (accept) begin
      op_q <= op_in;
      a_q  <= A;
      bsh  <= B;
      cnt  <= '0;
      acc  <= '0;
      if (!is_clmul(op_in)) begin
        Result <= simple_res;
      end
    end else if ((state == CALC) && !Flush) begin
      acc <= acc_n;
      bsh <= bsh_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        Result <= clmul_res;
      end
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Randomised + directed bench for iterative_alu
// against a whole-word arithmetic reference model.
module tb_iterative_alu;

  localparam int W = 64;
  localparam int P = 8;
  localparam int K = W / P;
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   Op;
  logic         W64;
  logic         Flush;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         Busy;

  int n_cmp = 0;
  int n_bad = 0;

  iterative_alu #(
    .WIDTH(W),
    .BPC  (P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .InValid (InValid),
    .InReady (InReady),
    .A       (A),
    .B       (B),
    .Op      (Op),
    .W64     (W64),
    .Flush   (Flush),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Result  (Result),
    .Busy    (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic w64);
    logic [127:0] p;
    logic [63:0]  r;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) p = p ^ ({64'b0, a} << i);
    end
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = {63'b0, $signed(a) < $signed(b)};
      3'd3: r = {63'b0, a < b};
      3'd4: r = p[63:0];
      3'd5: r = p[127:64];
      3'd6: r = p[126:63];
      default: r = a ^ b;
    endcase
    if (w64 && (op <= 3'd1)) begin
      r = {{32{r[31]}}, r[31:0]};
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op,
                                 input logic [63:0] b);
    int h;
    if (op < 3'd4 || op == 3'd7) return 1;
`ifdef ITERATIVE_ALU_EARLYOUT_EN
    if (b == 0) return 2;
    h = 0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) h = i;
    end
    return h / P + 2;
`else
    h = int'(b[0]);
    return K + 1 + h - h;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic w64,
                       input string tag);
    int lat;
    logic [63:0] exp;
    exp = model(op, a, b, w64);
    check({tag, "_inrdy"}, 64'(InReady), 64'd1);
    InValid = 1'b1;
    Op = op;
    A = a;
    B = b;
    W64 = w64;
    tick();
    InValid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    Op = 3'($urandom);
    W64 = 1'($urandom);
    lat = 1;
    while (!OutValid && lat < TMO) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, b)));
    check({tag, "_res"}, Result, exp);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, "_idle"}, 64'(InReady), 64'd1);
    if (lat >= TMO) do_reset();
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] exp;
    logic [2:0]  rop;
    int          seen;
    reset = 1'b1;
    InValid = 1'b0;
    A = '0;
    B = '0;
    Op = '0;
    W64 = 1'b0;
    Flush = 1'b0;
    OutReady = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    check("rst_inready", 64'(InReady), 64'd1);
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_result", Result, 64'd0);

    do_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add");
    do_op(3'd1, 64'd0, 64'd1, 1'b1, "subw");
    do_op(3'd0, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b1, "addw");
    do_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "slt");
    do_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "sltu");
    do_op(3'd2, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
          1'b0, "slt_ovf");
    do_op(3'd7, 64'hF0, 64'hFF, 1'b0, "xor");
    do_op(3'd4, 64'd3, 64'd3, 1'b0, "clmul33");
    do_op(3'd4, 64'h8000_0000_0000_0000, 64'd2, 1'b0, "clmul_hi");
    do_op(3'd5, 64'h8000_0000_0000_0000, 64'd2, 1'b0, "clmulh_hi");
    do_op(3'd6, 64'h8000_0000_0000_0000, 64'd2, 1'b0, "clmulr_hi");
    do_op(3'd4, 64'd5, 64'd1, 1'b0, "clmul_b1");
    do_op(3'd4, 64'd7, 64'd0, 1'b0, "clmul_b0");
    do_op(3'd5, 64'hDEAD_BEEF_1234_5678, 64'hFF00_0000_0000_0000,
          1'b0, "clmul_btop");

    // Output stall: result must hold while OutReady is low.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    exp = model(3'd5, ra, rb, 1'b0);
    InValid = 1'b1;
    Op = 3'd5;
    A = ra;
    B = rb;
    tick();
    InValid = 1'b0;
    seen = 1;
    while (!OutValid && seen < TMO) begin
      tick();
      seen++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(OutValid), 64'd1);
      check("stall_res", Result, exp);
      check("stall_inready", 64'(InReady), 64'd0);
      tick();
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check("stall_release", 64'(InReady), 64'd1);

    // Flush in the third CALC cycle.
    InValid = 1'b1;
    Op = 3'd4;
    A = 64'h1234;
    B = 64'hFF00_0000_0000_0000;
    tick();
    InValid = 1'b0;
    tick();
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_inready", 64'(InReady), 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (OutValid) seen++;
      tick();
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    do_op(3'd0, 64'd40, 64'd2, 1'b0, "post_flush_add");

    // Flush beats a simultaneous request.
    InValid = 1'b1;
    Flush = 1'b1;
    Op = 3'd0;
    A = 64'd1;
    B = 64'd1;
    tick();
    InValid = 1'b0;
    Flush = 1'b0;
    check("flush_acc_busy", 64'(Busy), 64'd0);
    tick();
    check("flush_acc_valid", 64'(OutValid), 64'd0);

    // Reset mid-calculation.
    InValid = 1'b1;
    Op = 3'd4;
    A = 64'h55;
    B = 64'hFF00_0000_0000_0000;
    tick();
    InValid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_calc_busy", 64'(Busy), 64'd0);
    check("rst_calc_valid", 64'(OutValid), 64'd0);
    check("rst_calc_result", Result, 64'd0);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom);
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = 64'($urandom_range(0, 255));
        1: rb = {32'b0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      do_op(rop, ra, rb, 1'($urandom), "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
